// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifq_pkg
// Brief    : Shared state encoding and PC helpers for the instruction fetch queue.
// Revision : 1.0
// ============================================================================
package ifq_pkg;

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // PCs are widened to this width before indexing so range checks never truncate.
    localparam int PC_EXT_W = 64;

    function automatic logic [PC_EXT_W-1:0] pc_to_word(input logic [PC_EXT_W-1:0] pc);
        return {2'b00, pc[PC_EXT_W-1:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifq_fifo
// Brief    : Synchronous prefetch FIFO with flush, occupancy count and head view.
// Revision : 1.0
// ============================================================================
module ifq_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);
    localparam logic [CNT_W-2:0] c_ptr_one = (CNT_W-1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-2:0] r_wr_ptr;
    logic [CNT_W-2:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = pop && (r_count != '0);
    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign w_do_push = push && ((r_count != c_full) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_queue
// Brief    : Loadable instruction RAM with auto-incrementing fetch, redirect and
//            a valid/ready prefetch queue towards the IF stage.
// Revision : 1.0
// ============================================================================
module instruction_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                ADDR_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [DATA_W-1:0] NOP        = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault,
    output logic              running
);

    localparam int WORD_AW = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_ent_w = DATA_W + ADDR_W + 1;
    localparam logic [c_cnt_w-1:0]  c_fifo_full   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [PC_EXT_W-1:0] c_depth_words = PC_EXT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]   c_pc_step     = ADDR_W'(4);

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_inflight_pc;
    logic                r_inflight_fault;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_ram [DEPTH];

    logic                w_run;
    logic                w_redirect;
    logic                w_pop;
    logic                w_push;
    logic                w_issue;
    logic                w_fetch_oor;
    logic [c_cnt_w-1:0]  w_count;
    logic [c_cnt_w-1:0]  w_occ_next;
    logic [c_ent_w-1:0]  w_push_data;
    logic [c_ent_w-1:0]  w_head;
    logic [PC_EXT_W-1:0] w_fetch_word;
    logic [PC_EXT_W-1:0] w_load_word;
    logic                w_unused;

    assign w_run        = (r_state == ST_RUN);
    assign w_redirect   = w_run && redirect_valid;
    assign w_pop        = out_valid && out_ready;
    assign w_fetch_word = pc_to_word(PC_EXT_W'(r_fetch_pc));
    assign w_load_word  = pc_to_word(PC_EXT_W'(load_addr));
    assign w_fetch_oor  = (w_fetch_word >= c_depth_words);
    assign w_unused     = ^{w_load_word, redirect_pc[1:0]};

    // Reserve a slot for the read already in flight so a full FIFO never overflows.
    assign w_occ_next  = w_count - c_cnt_w'(w_pop) + c_cnt_w'(r_inflight);
    assign w_issue     = w_run && !w_redirect && (w_occ_next < c_fifo_full);
    assign w_push      = r_inflight && !w_redirect;
    assign w_push_data = {(r_inflight_fault ? NOP : r_rd_data), r_inflight_pc, r_inflight_fault};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD: if (start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight       <= 1'b0;
            r_inflight_pc    <= '0;
            r_inflight_fault <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc    <= r_fetch_pc;
                r_inflight_fault <= w_fetch_oor;
            end
            if (!w_run && start)  r_fetch_pc <= RESET_PC;
            else if (w_redirect)  r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            else if (w_issue)     r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
    end

    // RAM contents survive reset; loads and fetches are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (!w_run && load_en) r_ram[w_load_word[WORD_AW-1:0]] <= load_data;
        if (w_issue)           r_rd_data <= r_ram[w_fetch_word[WORD_AW-1:0]];
    end

    ifq_fifo #(
        .WIDTH (c_ent_w),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (w_redirect),
        .count     (w_count),
        .head      (w_head)
    );

    assign out_valid = (w_count != '0);
    assign out_instr = out_valid ? w_head[c_ent_w-1 -: DATA_W] : NOP;
    assign out_pc    = out_valid ? w_head[ADDR_W:1] : '0;
    assign out_fault = out_valid && w_head[0];
    assign running   = w_run;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_queue
// Brief    : Scoreboard bench: expected fetch streams from a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 64;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          REFILL   = 80;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        running;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_mem [DEPTH];
    bit          model_run = 1'b0;
    exp_t        exp_q[$];

    instruction_fetch_queue #(
        .DATA_W     (32),
        .DEPTH      (DEPTH),
        .ADDR_W     (32),
        .FIFO_DEPTH (4),
        .RESET_PC   (RESET_PC),
        .NOP        (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .running        (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Expected stream after a (re)start: consecutive word PCs, NOP+fault past the RAM.
    task automatic refill(input logic [31:0] pc0);
        logic [31:0] pc;
        exp_t        e;
        pc = pc0;
        exp_q.delete();
        for (int i = 0; i < REFILL; i++) begin
            e.pc    = pc;
            e.fault = (pc >= 32'(DEPTH * 4));
            e.instr = e.fault ? NOP : model_mem[pc[7:2]];
            exp_q.push_back(e);
            pc = pc + 32'd4;
        end
    endtask

    // Apply the model effect of the inputs sampled at this rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_run = 1'b0;
            exp_q.delete();
        end else if (!model_run) begin
            if (load_en) model_mem[load_addr[7:2]] = load_data;
            if (start) begin
                model_run = 1'b1;
                refill(RESET_PC);
            end
        end else if (redirect_valid) begin
            refill({redirect_pc[31:2], 2'b00});
        end
        #1;
    endtask

    task automatic monitor();
        logic pv;
        logic pr;
        logic predir;
        int   idle;
        pv = 1'b0; pr = 1'b0; predir = 1'b0; idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                idle = 0;
            end else begin
                if (!model_run) check("idle_in_load", out_valid, 0);
                if (out_valid) begin
                    idle = 0;
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", out_valid, 0);
                    end else begin
                        check("head_instr", out_instr, exp_q[0].instr);
                        check("head_pc", out_pc, exp_q[0].pc);
                        check("head_fault", out_fault, exp_q[0].fault);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end else if (model_run) begin
                    if (pv && !pr && !predir) check("valid_drop", out_valid, 1);
                    idle = redirect_valid ? 0 : idle + 1;
                    if (idle > 2) begin
                        check("fetch_stall", out_valid, 1);
                        idle = 0;
                    end
                end
                pv = out_valid;
                pr = out_ready;
                predir = redirect_valid && model_run;
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        #3;
        check("rst_valid", out_valid, 0);
        check("rst_instr", out_instr, NOP);
        check("rst_pc", out_pc, 0);
        check("rst_fault", out_fault, 0);
        check("rst_running", running, 0);
        tick();
        tick();
        rst = 1'b0;

        // Program load; start shares the cycle with the final write.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 32'(i * 4);
            load_data = (i < 8) ? 32'h1111_1111 * 32'(i + 1) : $urandom;
            start     = (i == DEPTH - 1);
            tick();
        end
        load_en = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        check("lat_edge0", out_valid, 0);
        tick();
        check("lat_edge1", out_valid, 0);
        tick();
        check("lat_edge2", out_valid, 1);
        check("first_pc", out_pc, 0);
        repeat (8) begin
            tick();
            check("stream_gap", out_valid, 1);
        end

        // Backpressure from pc 0.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0;
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        repeat (10) begin
            check("bp_instr", out_instr, 32'h1111_1111);
            check("bp_pc", out_pc, 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (8) begin
            tick();
            check("bp_release_gap", out_valid, 1);
        end

        // Redirect while three entries are queued.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h13;
        tick();
        redirect_valid = 1'b0;
        check("redir_flush0", out_valid, 0);
        tick();
        check("redir_flush1", out_valid, 0);
        tick();
        check("redir_valid", out_valid, 1);
        check("redir_pc", out_pc, 32'h10);
        check("redir_instr", out_instr, 32'h5555_5555);
        out_ready = 1'b1;

        // Fetch running off the end of the RAM.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        check("oor_last_pc", out_pc, 32'hFC);
        check("oor_last_fault", out_fault, 0);
        tick();
        check("oor_pc", out_pc, 32'h100);
        check("oor_instr", out_instr, NOP);
        check("oor_fault", out_fault, 1);
        tick();
        check("oor_next_pc", out_pc, 32'h104);
        check("oor_next_fault", out_fault, 1);

        // Load and start are ignored while running.
        load_en = 1'b1;
        load_addr = 32'h0;
        load_data = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        load_en = 1'b0;
        start = 1'b0;
        repeat (4) tick();

        // Asynchronous reset mid-stream, then restart.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_running", running, 0);
        tick();
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_running", running, 1);
        tick();
        tick();
        check("restart_pc", out_pc, RESET_PC);
        check("restart_instr", out_instr, 32'h1111_1111);

        // Randomised traffic.
        repeat (1500) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0) || (model_run && exp_q.size() < 10);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 'h120));
            load_en        = ($urandom_range(0, 7) == 0);
            load_addr      = 32'($urandom_range(0, 255));
            load_data      = $urandom;
            start          = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        redirect_valid = 1'b0;
        load_en = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
